// File: rtl/spi_master_mc.sv
// spi_master_mc: multi-channel SPI master. Each frame is {rw, address, data},
// sent MSB first, with the SPI mode and chip select chosen per transaction
// and a fixed SCLK divider.
// Ports:
//   i_clk_sys, i_rst_n       : system clock and async active-low reset
//   i_start .. i_write_data  : request strobe and payload, accepted only when idle
//   o_read_data/o_data_valid : last read word and its one-cycle valid pulse
//   o_done, o_err, o_busy    : frame complete, request rejected, frame in flight
//   i_MISO, o_SCLK, o_MOSI   : serial lines
//   o_SEN                    : active-low chip selects, one per channel
module spi_master_mc #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 20,
  parameter int unsigned NUM_CS     = 4,
  parameter int unsigned CS_SEL_W   = 2,
  parameter int unsigned CLK_DIV    = 4,
  parameter logic [1:0]  RESET_MODE = 2'b00
) (
  input  logic                  i_clk_sys,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_rw,
  input  logic [1:0]            i_mode,
  input  logic [CS_SEL_W-1:0]   i_cs_sel,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  output logic [DATA_WIDTH-1:0] o_read_data,
  output logic                  o_data_valid,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_busy,
  input  logic                  i_MISO,
  output logic                  o_SCLK,
  output logic                  o_MOSI,
  output logic [NUM_CS-1:0]     o_SEN
);

  localparam int unsigned FRAME_BITS      = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned HALF_EDGES      = 2 * FRAME_BITS;
  localparam int unsigned HCNT_W          = $clog2(CLK_DIV + 1);
  localparam int unsigned BCNT_W          = $clog2(HALF_EDGES + 1);
  // SCLK edge index of the first data bit's leading edge
  localparam int unsigned FIRST_DATA_EDGE = 2 * (1 + ADDR_WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_LAG, S_GAP} state_t;

  state_t                  r_state, w_state_nxt;
  logic [HCNT_W-1:0]       r_hcnt, w_hcnt_nxt;
  logic [BCNT_W-1:0]       r_bcnt, w_bcnt_nxt;
  logic [1:0]              r_mode, w_mode_nxt;
  logic                    r_rw, w_rw_nxt;
  logic [FRAME_BITS-1:0]   r_tx, w_tx_nxt;
  logic [DATA_WIDTH-1:0]   r_rx, w_rx_nxt;
  logic [DATA_WIDTH-1:0]   r_rdata, w_rdata_nxt;
  logic                    r_sclk, w_sclk_nxt;
  logic                    r_mosi, w_mosi_nxt;
  logic [NUM_CS-1:0]       r_sen, w_sen_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_done, w_done_nxt;
  logic                    r_valid, w_valid_nxt;
  logic                    r_err, w_err_nxt;
  logic                    w_edge;
  logic                    w_hcnt_last;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [FRAME_BITS-1:0]   w_frame;

  assign w_hcnt_last = (r_hcnt == HCNT_W'(CLK_DIV - 1));
  // Reads shift zeros out during the data field
  assign w_wdata     = i_rw ? {DATA_WIDTH{1'b0}} : i_write_data;
  assign w_frame     = {i_rw, i_address, w_wdata};

  // State and all registered outputs
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_hcnt  <= '0;
      r_bcnt  <= '0;
      r_mode  <= RESET_MODE;
      r_rw    <= 1'b0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_rdata <= '0;
      r_sclk  <= RESET_MODE[1];
      r_mosi  <= 1'b0;
      r_sen   <= '1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_mode  <= w_mode_nxt;
      r_rw    <= w_rw_nxt;
      r_tx    <= w_tx_nxt;
      r_rx    <= w_rx_nxt;
      r_rdata <= w_rdata_nxt;
      r_sclk  <= w_sclk_nxt;
      r_mosi  <= w_mosi_nxt;
      r_sen   <= w_sen_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_bcnt_nxt  = r_bcnt;
    w_mode_nxt  = r_mode;
    w_rw_nxt    = r_rw;
    w_tx_nxt    = r_tx;
    w_rx_nxt    = r_rx;
    w_rdata_nxt = r_rdata;
    w_sclk_nxt  = r_sclk;
    w_mosi_nxt  = r_mosi;
    w_sen_nxt   = r_sen;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_edge      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_hcnt_nxt = '0;
        w_bcnt_nxt = '0;
        w_sclk_nxt = r_mode[1];
        w_mosi_nxt = 1'b0;
        w_sen_nxt  = '1;
        w_busy_nxt = 1'b0;
        if (i_start) begin
          if (32'(i_cs_sel) >= NUM_CS) begin
            w_err_nxt = 1'b1;
          end else begin
            w_state_nxt = S_LEAD;
            w_busy_nxt  = 1'b1;
            w_mode_nxt  = i_mode;
            w_rw_nxt    = i_rw;
            w_rx_nxt    = '0;
            w_sen_nxt   = ~(NUM_CS'(1) << i_cs_sel);
            // Idle level follows the new CPOL a full LEAD before the first edge
            w_sclk_nxt  = i_mode[1];
            if (!i_mode[0]) begin
              // CPHA=0 presents bit 0 while CS settles
              w_mosi_nxt = w_frame[FRAME_BITS-1];
              w_tx_nxt   = w_frame << 1;
            end else begin
              w_tx_nxt   = w_frame;
            end
          end
        end
      end
      S_LEAD: begin
        if (w_hcnt_last) begin
          w_hcnt_nxt  = '0;
          w_state_nxt = S_SHIFT;
          w_edge      = 1'b1;
        end else begin
          w_hcnt_nxt = r_hcnt + HCNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (w_hcnt_last) begin
          w_hcnt_nxt = '0;
          // After the last half-period SCLK is already back at idle
          if (r_bcnt == BCNT_W'(HALF_EDGES)) w_state_nxt = S_LAG;
          else                                w_edge      = 1'b1;
        end else begin
          w_hcnt_nxt = r_hcnt + HCNT_W'(1);
        end
      end
      S_LAG: begin
        if (w_hcnt_last) begin
          w_hcnt_nxt  = '0;
          w_state_nxt = S_GAP;
          w_sen_nxt   = '1;
          w_mosi_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          if (r_rw) begin
            w_valid_nxt = 1'b1;
            w_rdata_nxt = r_rx;
          end
        end else begin
          w_hcnt_nxt = r_hcnt + HCNT_W'(1);
        end
      end
      S_GAP: begin
        if (w_hcnt_last) begin
          w_hcnt_nxt  = '0;
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_hcnt_nxt = r_hcnt + HCNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // r_bcnt is the index of the SCLK edge being taken; even = leading
    if (w_edge) begin
      w_sclk_nxt = ~r_sclk;
      w_bcnt_nxt = r_bcnt + BCNT_W'(1);
      if (r_bcnt[0] == r_mode[0]) begin
        // Sample edge: leading for CPHA=0, trailing for CPHA=1
        if (r_bcnt >= BCNT_W'(FIRST_DATA_EDGE))
          w_rx_nxt = (r_rx << 1) | DATA_WIDTH'(i_MISO);
      end else if (r_bcnt != BCNT_W'(HALF_EDGES - 1)) begin
        w_mosi_nxt = r_tx[FRAME_BITS-1];
        w_tx_nxt   = r_tx << 1;
      end
    end
  end

  assign o_read_data  = r_rdata;
  assign o_data_valid = r_valid;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_busy       = r_busy;
  assign o_SCLK       = r_sclk;
  assign o_MOSI       = r_mosi;
  assign o_SEN        = r_sen;

endmodule
